// File: rtl/alu_sched_pkg.sv
// Shared encodings and helpers for the round-robin ALU scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package alu_sched_pkg;

   // ALU op encodings as seen on req_op / alu_op
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Requester index k positions after ptr, wrapping modulo n (n need not be a power of two)
   function automatic int rr_idx(input int ptr, input int k, input int n);
      return (ptr + k) % n;
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: en=0 suppresses every grant; no state is held here.
//
// Ports:
//   req      in   NREQ   request vector
//   ptr      in   IDW    index of the most recent winner (lowest priority now)
//   en       in   1      grant enable
//   gnt      out  NREQ   one-hot grant, zero when no grant
//   gnt_idx  out  IDW    encoded grant index (0 when no grant)
//   gnt_vld  out  1      a grant is issued
module rr_arbiter
   import alu_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_vld
);

   // Scan in rotated priority order: ptr+1 first, ptr itself last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      if (en) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_vld && req[rr_idx(int'(ptr), k, NREQ)]) begin
               gnt_vld                           = 1'b1;
               gnt[rr_idx(int'(ptr), k, NREQ)]   = 1'b1;
               gnt_idx                           = IDW'(rr_idx(int'(ptr), k, NREQ));
            end
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU among NREQ requesters with round-robin arbitration.
// Latency: grant cycle -> ALU cycle -> response valid (1 op per 2 cycles sustained).
// Backpressure: rsp_ready=0 holds the response and blocks new grants; ena=0 blocks grants only.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ena                              global grant enable
//   req_valid/req_ready              per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op               packed operands, requester i at [i*DW +: DW] / [i*2 +: 2]
//   alu_a/alu_b/alu_op               registered operands to the ALU, zero outside EXEC
//   alu_res/alu_cout                 ALU result, captured verbatim
//   rsp_valid/rsp_ready              response handshake
//   rsp_id/rsp_res/rsp_cout          response payload
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [1:0]        alu_op,
   input  logic [DW-1:0]     alu_res,
   input  logic              alu_cout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [DW-1:0]     rsp_res,
   output logic              rsp_cout
);

   // Pointer starts at the last requester so requester 0 wins first after reset.
   localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   op_id_q, op_id_d;
   logic [DW-1:0]    alu_a_q, alu_a_d;
   logic [DW-1:0]    alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [DW-1:0]    rsp_res_q, rsp_res_d;
   logic             rsp_cout_q, rsp_cout_d;

   logic             arb_en;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_vld;

   // Accept slots: IDLE, or RESP in the cycle the response leaves.
   assign arb_en = ena && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // The grant is combinational, so mask it while reset is held: the state
   // reads IDLE during reset and would otherwise present ready.
   assign req_ready = rst_n ? gnt : '0;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      op_id_d     = op_id_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_res_d   = rsp_res_q;
      rsp_cout_d  = rsp_cout_q;

      case (state_q)
         IDLE: ;
         EXEC: begin
            rsp_res_d   = alu_res;
            rsp_cout_d  = alu_cout;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            // Park the ALU inputs at zero once the op has been captured
            alu_a_d     = '0;
            alu_b_d     = '0;
            alu_op_d    = '0;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A grant only arises in an accept slot; it overrides the IDLE/RESP exit.
      if (gnt_vld) begin
         alu_a_d  = req_a[gnt_idx*DW +: DW];
         alu_b_d  = req_b[gnt_idx*DW +: DW];
         alu_op_d = req_op[gnt_idx*2 +: 2];
         op_id_d  = gnt_idx;
         ptr_d    = gnt_idx;
         state_d  = EXEC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= PTR_RST;
         op_id_q     <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_res_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         op_id_q     <= op_id_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_res_q   <= rsp_res_d;
         rsp_cout_q  <= rsp_cout_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_res   = rsp_res_q;
   assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus a random phase, checked
// against a transaction-level model (rotation order, response timing, ALU arithmetic).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_rr_scheduler;

   localparam int NREQ = 4;
   localparam int DW   = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ena;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ*2-1:0] req_op;
   logic [DW-1:0]     alu_a, alu_b, alu_res;
   logic [1:0]        alu_op;
   logic              alu_cout;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [DW-1:0]     rsp_res;
   logic              rsp_cout;

   always #5 clk = ~clk;

   alu_rr_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_res   (alu_res),
      .alu_cout  (alu_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_res   (rsp_res),
      .rsp_cout  (rsp_cout)
   );

   // Behavioural 4-bit ALU hanging off the scheduler's ALU port
   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      case (alu_op)
         2'b00: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01: begin alu_res = alu_a - alu_b; alu_cout = (alu_a < alu_b); end
         2'b10: alu_res = alu_a & alu_b;
         default: alu_res = alu_a | alu_b;
      endcase
   end

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level reference model
   int  last_g;
   bit  ex_pend;
   int  ex_id, ex_a, ex_b, ex_op;
   bit  rs_have;
   int  rs_id, rs_res, rs_cout;
   int  cyc = 0;
   int  done_ids[$];
   int  done_val[$];   // res | cout<<4 of each completed response
   int  acc_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic alu_ref(input int op, input int a, input int b, output int r, output int c);
      int s;
      r = 0; c = 0;
      case (op)
         0: begin s = a + b; r = s % 16; c = s / 16; end
         1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
         2: r = a & b;
         default: r = a | b;
      endcase
   endtask

   task automatic model_reset();
      last_g  = NREQ - 1;
      ex_pend = 0;
      rs_have = 0;
   endtask

   task automatic set_req(input int i, input int a, input int b, input int op);
      req_a[i*DW +: DW] = DW'(a);
      req_b[i*DW +: DW] = DW'(b);
      req_op[i*2 +: 2]  = 2'(op);
   endtask

   // One clock: check outputs on the falling edge, advance the model, return just after the rising edge.
   task automatic cycle();
      bit allowed;
      int g, idx, r, c;
      @(negedge clk);
      cyc++;
      if (!rst_n) model_reset();
      chk("alu_a",  alu_a,  ex_pend ? ex_a  : 0);
      chk("alu_b",  alu_b,  ex_pend ? ex_b  : 0);
      chk("alu_op", alu_op, ex_pend ? ex_op : 0);
      chk("rsp_valid", rsp_valid, rs_have);
      if (rs_have) begin
         chk("rsp_id",   rsp_id,   rs_id);
         chk("rsp_res",  rsp_res,  rs_res);
         chk("rsp_cout", rsp_cout, rs_cout);
      end
      allowed = rst_n && ena && !ex_pend && (!rs_have || rsp_ready);
      g = -1;
      if (allowed) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (last_g + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
      if (rst_n) begin
         if (rs_have && rsp_ready) begin
            done_ids.push_back(rs_id);
            done_val.push_back(rs_res | (rs_cout << 4));
            rs_have = 0;
         end
         if (ex_pend) begin
            alu_ref(ex_op, ex_a, ex_b, r, c);
            rs_have = 1; rs_id = ex_id; rs_res = r; rs_cout = c;
            ex_pend = 0;
         end
         if (g >= 0) begin
            ex_pend = 1; ex_id = g;
            ex_a  = int'(req_a[g*DW +: DW]);
            ex_b  = int'(req_b[g*DW +: DW]);
            ex_op = int'(req_op[g*2 +: 2]);
            last_g = g;
            acc_cyc.push_back(cyc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int n0;
      rst_n = 1'b0; ena = 1'b1; rsp_ready = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
      model_reset();

      // 1. Reset with every request valid: nothing may be granted
      req_valid = 4'hF;
      run(3);
      rst_n = 1'b1;
      req_valid = '0;
      run(1);

      // 2. Single ops from requester 0: ADD 5+3, then SUB 3-5
      set_req(0, 5, 3, 0);
      req_valid = 4'b0001;
      run(1);
      req_valid = '0;
      run(3);
      chk("t2_add_id", done_ids[$], 0);
      chk("t2_add_val", done_val[$], 8);
      set_req(0, 3, 5, 1);
      req_valid = 4'b0001;
      run(1);
      req_valid = '0;
      run(3);
      chk("t2_sub_val", done_val[$], 30);

      // 3. Round-robin from reset with all four requesting
      do_reset();
      done_ids.delete(); acc_cyc.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 2 * i, i);
      req_valid = 4'hF;
      run(12);
      req_valid = '0;
      run(2);
      chk("t3_order0", done_ids[0], 0);
      chk("t3_order1", done_ids[1], 1);
      chk("t3_order2", done_ids[2], 2);
      chk("t3_order3", done_ids[3], 3);
      chk("t3_order4", done_ids[4], 0);
      for (int i = 0; i < 4; i++) chk("t3_spacing", acc_cyc[i+1] - acc_cyc[i], 2);

      // 4. Backpressure: response held 5 cycles, then release grants in the same cycle
      do_reset();
      set_req(0, 9, 9, 0); set_req(1, 7, 1, 1);
      req_valid = 4'b0011;
      rsp_ready = 1'b0;
      run(2 + 5);
      rsp_ready = 1'b1;
      #1;
      chk("t4_grant_on_release", req_ready, 4'b0010);
      run(1);
      req_valid = '0;
      run(3);

      // 5. Enable: no grant while low; dropping it mid-op still delivers the result
      ena = 1'b0;
      req_valid = 4'b0010;
      n0 = acc_cyc.size();
      run(10);
      chk("t5_no_grant", acc_cyc.size(), n0);
      set_req(1, 12, 10, 2);
      ena = 1'b1;
      run(1);
      ena = 1'b0;
      req_valid = '0;
      run(3);
      chk("t5_and_id", done_ids[$], 1);
      chk("t5_and_val", done_val[$], 8);
      ena = 1'b1;

      // 6. Reset while a response is pending
      set_req(2, 1, 1, 0);
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      run(2);
      chk("t6_in_resp", rsp_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_drop", rsp_valid, 1'b0);
      req_valid = 4'b0101;
      rsp_ready = 1'b1;
      run(1);
      rst_n = 1'b1;
      #1;
      chk("t6_req0_first", req_ready, 4'b0001);
      run(1);
      req_valid = '0;
      run(3);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         req_valid = NREQ'($urandom);
         req_a  = NREQ*DW'($urandom);
         req_b  = NREQ*DW'($urandom);
         req_op = (NREQ*2)'($urandom);
         ena       = ($urandom_range(9) != 0);
         rsp_ready = ($urandom_range(9) < 7);
         run(1);
      end
      req_valid = '0; ena = 1'b1; rsp_ready = 1'b1;
      run(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
